// File: rtl/sdio_master_pkg.sv
// rtl/sdio_master_pkg.sv - shared types and helpers for the 3-wire serial master
package sdio_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CSHIGH
    } state_e;

    localparam logic SDIO_RD = 1'b1;
    localparam logic SDIO_WR = 1'b0;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/sdio_sclk_gen.sv
// rtl/sdio_sclk_gen.sv - half-period counter producing sclk and edge strobes
module sdio_sclk_gen #(
    parameter int CLK_DIV = 4,
    parameter int CW      = $clog2(CLK_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    output logic          sclk_o,
    output logic          rise_stb_o,
    output logic          fall_stb_o,
    output logic [CW-1:0] cnt_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          sclk_q;
    logic          wrap;

    assign wrap       = en_i && (cnt_q == CNT_LAST);
    assign rise_stb_o = wrap && !sclk_q;
    assign fall_stb_o = wrap && sclk_q;
    assign sclk_o     = sclk_q;
    assign cnt_o      = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (wrap) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sdio_master.sv
// rtl/sdio_master.sv - command-to-frame serialiser for the 3-wire register bus
module sdio_master
    import sdio_master_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rnw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sclk,
    output logic              cs_n,
    output logic              sdio_o,
    output logic              sdio_oe,
    input  logic              sdio_i
);

    localparam int N  = frame_len(ADDR_W, DATA_W);
    localparam int BW = $clog2(N + 1);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [BW-1:0] BIT_TA   = BW'(ADDR_W);
    localparam logic [CW-1:0] CS_LAST  = CW'(CLK_DIV - 2);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("sdio_master: CLK_DIV must be >= 2");
    end

    state_e            state_q, state_d;
    logic              rnw_q, rnw_d;
    logic [N-2:0]      tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              cs_n_q, cs_n_d;
    logic              sdio_o_q, sdio_o_d;
    logic              sdio_oe_q, sdio_oe_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic          gen_en, rise_stb, fall_stb;
    logic [CW-1:0] gen_cnt;

    assign gen_en = (state_q != IDLE);

    sdio_sclk_gen #(.CLK_DIV(CLK_DIV), .CW(CW)) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (gen_en),
        .sclk_o     (sclk),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb),
        .cnt_o      (gen_cnt)
    );

    always_comb begin
        state_d     = state_q;
        rnw_d       = rnw_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_d       = bit_q;
        cs_n_d      = cs_n_q;
        sdio_o_d    = sdio_o_q;
        sdio_oe_d   = sdio_oe_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SHIFT;
                    rnw_d     = cmd_rnw;
                    tx_d      = {cmd_addr, cmd_wdata};
                    rx_d      = '0;
                    bit_d     = '0;
                    cs_n_d    = 1'b0;
                    sdio_oe_d = 1'b1;
                    sdio_o_d  = cmd_rnw;
                end
            end
            SHIFT: begin
                // Only a released line is sampled, so slave-side X never enters rx.
                if (rise_stb && !sdio_oe_q) begin
                    rx_d = {rx_q[DATA_W-2:0], sdio_i};
                end
                if (fall_stb) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d     = CSHIGH;
                        cs_n_d      = 1'b1;
                        sdio_oe_d   = 1'b0;
                        sdio_o_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = (rnw_q == SDIO_WR) ? '0 : rx_q;
                    end else if (rnw_q == SDIO_RD && bit_q == BIT_TA) begin
                        sdio_oe_d = 1'b0;
                        sdio_o_d  = 1'b0;
                    end else if (sdio_oe_q) begin
                        sdio_o_d = tx_q[N-2];
                        tx_d     = tx_q << 1;
                    end
                end
            end
            CSHIGH: begin
                // Leave one cycle early so the next accept edge lands a half-period after cs_n rose.
                if (gen_cnt == CS_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnw_q       <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_q       <= '0;
            cs_n_q      <= 1'b1;
            sdio_o_q    <= 1'b0;
            sdio_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rnw_q       <= rnw_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_q       <= bit_d;
            cs_n_q      <= cs_n_d;
            sdio_o_q    <= sdio_o_d;
            sdio_oe_q   <= sdio_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign cs_n      = cs_n_q;
    assign sdio_o    = sdio_o_q;
    assign sdio_oe   = sdio_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/sdio_master.md
Name: sdio_master

Overview:
- 3-wire half-duplex serial master that generates sclk, cs_n and sdio for the register-access serial bus.
- Sits directly upstream of the serial bus interface and the slave DUT on that bus.
- Accepts parallel read/write commands via a valid/ready handshake and serialises them as a frame: rnw bit, then address, then data, MSB first.
- For reads it releases sdio after the address and captures the slave's data bits.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal >= 2, elaboration-time check.
- ADDR_W, 7, address width.
- DATA_W, 8, data width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master idle and able to accept.
- cmd_rnw  input  1  1 = read, 0 = write.
- cmd_addr  input  ADDR_W  register address.
- cmd_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse when a frame completes.
- rsp_rdata  output  DATA_W  captured read data; 0 for writes.
- sclk  output  1  serial clock, idles low.
- cs_n  output  1  chip select, active low.
- sdio_o  output  1  serial data out.
- sdio_oe  output  1  sdio drive enable; the top level resolves the tri-state wire as sdio_oe ? sdio_o : 'z.
- sdio_i  input  1  sampled serial data in.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: sclk=0, cs_n=1, sdio_o=0, sdio_oe=0, rsp_valid=0, rsp_rdata=0, state=IDLE.
- cmd_ready = (state==IDLE); it is 1 during and after reset.
- Frame length N = 1+ADDR_W+DATA_W (default 16). The frame is {rnw, addr, data}.
- States:
  - IDLE -> SHIFT on cmd_valid && cmd_ready, at clock edge T0.
  - SHIFT -> CSHIGH after the falling sclk edge of bit N.
  - CSHIGH -> IDLE after one half-period.
- IDLE:
  - At T0: latch the command, cs_n<=0, sdio_oe<=1, sdio_o<=rnw.
  - Half-period counter restarts at 0.
- SHIFT:
  - The counter wraps every CLK_DIV cycles; each wrap toggles sclk.
  - Bit k (1..N) rises at T0+(2k-1)*CLK_DIV and falls at T0+2k*CLK_DIV.
  - The first rising edge is a full half-period after cs_n falls (setup time).
  - sdio_o changes only on falling edges; the slave samples on rising edges.
  - Reads: at the falling edge of bit 1+ADDR_W, sdio_oe<=0 (turnaround), and sdio_o is held 0.
  - Reads: sdio_i is sampled at the rising edges of bits ADDR_W+2..N and shifted into rdata MSB first.
  - While sdio_oe=1, sdio_i is ignored; X on it must not reach rsp_rdata.
  - Writes: sdio_oe stays 1 for the whole frame.
- At the falling edge of bit N (T0+2N*CLK_DIV):
  - sclk<=0, cs_n<=1, sdio_oe<=0, sdio_o<=0.
  - rsp_valid<=1 for exactly one cycle, with rsp_rdata (reads) or 0 (writes).
- CSHIGH: cs_n stays high for CLK_DIV cycles. cmd_ready returns at T0+(2N+1)*CLK_DIV.
- Default latency (CLK_DIV=4, N=16): rsp_valid at T0+128; next accept possible at T0+132.
- Back-to-back: a cmd_valid held high is accepted at the first cycle cmd_ready=1. There are no bubbles beyond the CSHIGH half-period.
- cmd_valid while busy: no effect; no queueing.
- cmd_* inputs are sampled only at the accept edge; later changes are ignored.
- Reset mid-frame: all outputs immediately go to their reset values. No rsp_valid pulse; the frame is abandoned.
- rsp_rdata holds its value until the next rsp_valid.

Decomposition:
- Package sdio_master_pkg:
  - state enum {IDLE, SHIFT, CSHIGH};
  - localparam function frame_len(ADDR_W, DATA_W);
  - rnw encoding constants SDIO_RD=1, SDIO_WR=0.
- Sub-module sdio_sclk_gen:
  - half-period counter with enable;
  - outputs sclk plus one-cycle rise_stb and fall_stb strobes aligned to the toggle edge;
  - cleared by rst_n and when disabled.
- The top block holds the FSM, bit counter and the two shift registers.

Test Plan:
- Write, addr 0x15, data 0xA5, CLK_DIV=4 -> sampled on rising edges, sdio is 0, 0010101, 10100101. sdio_oe=1 throughout. rsp_valid at T0+128 with rsp_rdata=0. cmd_ready at T0+132.
- Read, addr 0x7F, slave model drives 0x3C after turnaround -> sdio_oe falls at T0+64. rsp_rdata=0x3C with rsp_valid at T0+128. sdio_o=0 while released.
- cmd_valid held high through a write followed by a read -> second accept exactly at T0+132. cs_n high exactly 4 cycles. Exactly two rsp_valid pulses.
- rst_n asserted at T0+50 during a write -> in the same timestep sclk=0, cs_n=1, sdio_oe=0. No rsp_valid. After release, a read of addr 0x01 completes normally.
- CLK_DIV=2 read with sdio_i=X while sdio_oe=1, slave returns 0x81 -> rsp_rdata=0x81 with no X bits. rsp_valid at T0+64.
